// File: rtl/id_stage_pkg.sv
// Shared constants for the decode stage: run states, opcode encodings, instruction field slices.
// The optional EX/MEM bypass is enabled with the ID_FORWARDING_EN macro in id_stage.
package id_stage_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    localparam logic EXEC = 1'b1;
    localparam logic IDLE = 1'b0;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 11;
    localparam int R1_MSB   = 10;
    localparam int R1_LSB   = 8;
    localparam int R2_MSB   = 6;
    localparam int R2_LSB   = 4;
    localparam int R3_MSB   = 2;
    localparam int R3_LSB   = 0;
    localparam int VAL3_MSB = 3;
    localparam int VAL8_MSB = 7;

    typedef enum logic [4:0] {
        OP_NOP   = 5'b00000, OP_HALT  = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011,
        OP_SLL   = 5'b00100, OP_SLA   = 5'b00101, OP_SRL  = 5'b00110, OP_SRA   = 5'b00111,
        OP_ADD   = 5'b01000, OP_ADDI  = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI  = 5'b01011,
        OP_CMP   = 5'b01100, OP_AND   = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111,
        OP_LDIH  = 5'b10000, OP_ADDC  = 5'b10001, OP_SUBC = 5'b10010,
        OP_JUMP  = 5'b11000, OP_JMPR  = 5'b11001, OP_BZ   = 5'b11010, OP_BNZ   = 5'b11011,
        OP_BN    = 5'b11100, OP_BNN   = 5'b11101, OP_BC   = 5'b11110, OP_BNC   = 5'b11111
    } opcode_e;

    typedef enum logic [1:0] {A_ZERO = 2'd0, A_R1 = 2'd1, A_R2 = 2'd2} a_sel_e;
    typedef enum logic [2:0] {B_ZERO = 3'd0, B_R3 = 3'd1, B_VAL3 = 3'd2, B_VAL8 = 3'd3, B_HI8 = 3'd4} b_sel_e;

    typedef struct packed {
        a_sel_e a_sel;
        b_sel_e b_sel;
        logic   store;
    } dec_t;

    function automatic dec_t decode_op(input logic [4:0] op);
        dec_t d;
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
            OP_CMP, OP_AND, OP_OR, OP_XOR:        d = '{A_R2, B_R3, 1'b0};
            OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: d = '{A_R2, B_VAL3, 1'b0};
            OP_STORE:                             d = '{A_R2, B_VAL3, 1'b1};
            OP_ADDI, OP_SUBI, OP_JMPR, OP_BZ, OP_BNZ,
            OP_BN, OP_BNN, OP_BC, OP_BNC:         d = '{A_R1, B_VAL8, 1'b0};
            OP_LDIH:                              d = '{A_R1, B_HI8, 1'b0};
            default:                              d = '{A_ZERO, B_ZERO, 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_gr_file.sv
// 8x16 general-register file: three combinational read ports with write-through
// from the write-back port, one synchronous write port, synchronous reset.
module id_stage_gr_file
    import id_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              byp_en,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic [REG_AW-1:0] raddr_s,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_s
);

    logic [DATA_W-1:0] gr_r [NREG];

    // Register array: cleared on reset, written only when write-back commits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                gr_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            gr_r[waddr] <= wdata;
        end
    end

    // Reads see a same-cycle write-back value before it lands in the array.
    always_comb begin
        rdata_a = (byp_en && (waddr == raddr_a)) ? wdata : gr_r[raddr_a];
        rdata_b = (byp_en && (waddr == raddr_b)) ? wdata : gr_r[raddr_b];
        rdata_s = (byp_en && (waddr == raddr_s)) ? wdata : gr_r[raddr_s];
    end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage: register read, bypass resolution, operand selection.
// Define ID_FORWARDING_EN to honour the EX/MEM bypass inputs; otherwise only WB write-through applies.
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              state,
    input  logic [DATA_W-1:0] id_ir,
    input  logic              jump,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              fwd_ex_en,
    input  logic [REG_AW-1:0] fwd_ex_addr,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic              fwd_mem_en,
    input  logic [REG_AW-1:0] fwd_mem_addr,
    input  logic [DATA_W-1:0] fwd_mem_data,
    output logic [DATA_W-1:0] ex_ir,
    output logic [DATA_W-1:0] reg_A,
    output logic [DATA_W-1:0] reg_B,
    output logic [DATA_W-1:0] smdr
);

    logic [4:0]        op_s;
    logic [REG_AW-1:0] r1_s, r2_s, r3_s;
    dec_t              dec_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s, rf_s_s;
    logic [DATA_W-1:0] res_a_s, res_b_s, res_s_s;
    logic [DATA_W-1:0] opa_s, opb_s, sd_s;

    assign op_s  = id_ir[OP_MSB:OP_LSB];
    assign r1_s  = id_ir[R1_MSB:R1_LSB];
    assign r2_s  = id_ir[R2_MSB:R2_LSB];
    assign r3_s  = id_ir[R3_MSB:R3_LSB];
    assign dec_s = decode_op(op_s);

    // Port a serves r2, port b serves r3, port s serves r1 (base/immediate source and store data).
    id_stage_gr_file u_gr_file (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wb_we && (state == EXEC)),
        .byp_en  (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (r2_s),
        .raddr_b (r3_s),
        .raddr_s (r1_s),
        .rdata_a (rf_a_s),
        .rdata_b (rf_b_s),
        .rdata_s (rf_s_s)
    );

`ifdef ID_FORWARDING_EN
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] idx,     input logic [DATA_W-1:0] rf,
        input logic              ex_en,   input logic [REG_AW-1:0] ex_addr,  input logic [DATA_W-1:0] ex_data,
        input logic              mem_en,  input logic [REG_AW-1:0] mem_addr, input logic [DATA_W-1:0] mem_data);
        logic [DATA_W-1:0] v;
        if (ex_en && (ex_addr == idx)) begin
            v = ex_data;
        end else if (mem_en && (mem_addr == idx)) begin
            v = mem_data;
        end else begin
            v = rf;
        end
        return v;
    endfunction

    // Youngest in-flight result wins: EX over MEM over WB/register file.
    always_comb begin
        res_a_s = resolve(r2_s, rf_a_s, fwd_ex_en, fwd_ex_addr, fwd_ex_data, fwd_mem_en, fwd_mem_addr, fwd_mem_data);
        res_b_s = resolve(r3_s, rf_b_s, fwd_ex_en, fwd_ex_addr, fwd_ex_data, fwd_mem_en, fwd_mem_addr, fwd_mem_data);
        res_s_s = resolve(r1_s, rf_s_s, fwd_ex_en, fwd_ex_addr, fwd_ex_data, fwd_mem_en, fwd_mem_addr, fwd_mem_data);
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{fwd_ex_en, fwd_ex_addr, fwd_ex_data, fwd_mem_en, fwd_mem_addr, fwd_mem_data};

    // Without bypass, hazards against EX/MEM are left to software.
    always_comb begin
        res_a_s = rf_a_s;
        res_b_s = rf_b_s;
        res_s_s = rf_s_s;
    end
`endif

    // Operand selection from the decoded class of the instruction.
    always_comb begin
        opa_s = {DATA_W{1'b0}};
        opb_s = {DATA_W{1'b0}};
        sd_s  = {DATA_W{1'b0}};
        case (dec_s.a_sel)
            A_R2:    opa_s = res_a_s;
            A_R1:    opa_s = res_s_s;
            default: opa_s = {DATA_W{1'b0}};
        endcase
        case (dec_s.b_sel)
            B_R3:    opb_s = res_b_s;
            B_VAL3:  opb_s = {{(DATA_W-VAL3_MSB-1){1'b0}}, id_ir[VAL3_MSB:0]};
            B_VAL8:  opb_s = {{(DATA_W-VAL8_MSB-1){1'b0}}, id_ir[VAL8_MSB:0]};
            B_HI8:   opb_s = {id_ir[VAL8_MSB:0], {(DATA_W-VAL8_MSB-1){1'b0}}};
            default: opb_s = {DATA_W{1'b0}};
        endcase
        if (dec_s.store) begin
            sd_s = res_s_s;
        end else begin
            sd_s = {DATA_W{1'b0}};
        end
    end

    // Pipeline register toward EX: reset, bubble on jump, load on exec, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_ir <= {DATA_W{1'b0}};
            reg_A <= {DATA_W{1'b0}};
            reg_B <= {DATA_W{1'b0}};
            smdr  <= {DATA_W{1'b0}};
        end else if (state == EXEC) begin
            if (jump) begin
                ex_ir <= {DATA_W{1'b0}};
                reg_A <= {DATA_W{1'b0}};
                reg_B <= {DATA_W{1'b0}};
                smdr  <= {DATA_W{1'b0}};
            end else begin
                ex_ir <= id_ir;
                reg_A <= opa_s;
                reg_B <= opb_s;
                smdr  <= sd_s;
            end
        end
    end

endmodule
